fpu_add_arbiter: RTL
====================

# fpu_add_arbiter

Shares one single-precision FP add datapath (operand alignment, add, normalize/round) between two requesters, e.g. the integer-pipe FP issue port and a second FP issue port. Round-robin arbitration, a registered issue stage toward the adder, an order queue of requester IDs for outstanding operations, and registered response routing back to the originating requester. Subtraction is folded in by flipping the sign of operand 2 before issue.

## Interface
- MAX_OUTSTANDING, 4: maximum operations in flight. Counted from grant until the adder returns the result. Power of two, ≥2.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  (N=0,1) request present.
- reqN_ready  out  1  request accepted this cycle when valid&ready.
- reqN_op1, reqN_op2  in  32  IEEE-754 single operands.
- reqN_sub  in  1  1 = op1 − op2.
- reqN_frm  in  3  rounding mode, passed through unchanged.
- add_valid  out  1  issue register holds an operation for the adder.
- add_ready  in  1  adder accepts issue this cycle.
- add_op1, add_op2  out  32  operands to the adder; op2 sign already adjusted.
- add_frm  out  3  rounding mode to the adder.
- add_done  in  1  adder returns one result (in issue order, no backpressure).
- add_result  in  32  result value.
- add_flags  in  5  fflags {NV,DZ,OF,UF,NX}.
- rspN_valid  out  1  one-cycle result pulse to requester N; no backpressure.
- rspN_result  out  32  result; rspN_flags  out  5  flags.
- err_orphan  out  1  sticky; set on add_done with empty order queue.

## Operation
- Grant condition: outstanding count < MAX_OUTSTANDING and the issue register is free (!add_valid or add_ready this cycle).
- If the grant condition fails, both reqN_ready are 0.
- reqN_ready is combinational from valids, pointer, count and add_ready; it never depends on add_done.
- Arbitration: round-robin pointer `prio` (0 or 1).
  - Both valid: grant req[prio], then prio ← other.
  - One valid: grant it; prio ← the other one.
  - None valid: prio holds.
- On grant:
  - Load the issue register: op1, {op2[31]^sub, op2[30:0]}, frm.
  - Push the requester ID into the order queue.
  - count++.
- On add_done:
  - Pop the order queue and count--.
  - Register {result, flags} onto the rsp port of the popped ID; pulse its rspN_valid for 1 cycle.
  - The other rsp port's valid is 0.
- Simultaneous grant and add_done: count is unchanged, and push and pop both occur.
  - When count == MAX_OUTSTANDING at cycle start, grant is blocked even if add_done arrives that cycle.
- add_done with empty queue: set err_orphan, no response, count stays 0.
- rspN_result/flags hold their last value when not valid.

## Timing
- Reset values:
  - add_valid=0, rsp0_valid=rsp1_valid=0, err_orphan=0.
  - prio=0, count=0, queue pointers 0.
  - add_op1/op2/frm and rsp data = 0.
- Request handshake at cycle T → add_valid=1 with data at T+1, held stable until add_ready.
- add_done at cycle M → rspN_valid at M+1.
- Best-case throughput: one grant per cycle while add_ready=1 and count < MAX_OUTSTANDING.
- Reset mid-operation: all in-flight state is discarded immediately. The adder shares RST, so no stale add_done is expected.

## Structure
- Package fpu_arb_pkg:
  - typedef fpu_add_req_t {op1, op2, sub, frm}.
  - typedef fpu_add_rsp_t {result, flags}.
  - typedef req_id_t (1 bit).
  - localparam FFLAGS_W=5.
- Sub-module fpu_tag_fifo:
  - Parameterized depth MAX_OUTSTANDING, width 1.
  - Ports: push, pop, din, dout, empty, full; asynchronous active-high reset.
  - Count and full come from the FIFO.
- Top level: arbiter, issue register, response registers, err_orphan.

## Test plan
- Single request: req0 op1=0x3F800000, op2=0x40000000, sub=0; adder stub returns 0x40400000 after 3 cycles → add_op2=0x40000000 at T+1; rsp0_valid at M+1 with 0x40400000; rsp1_valid stays 0.
- Subtract: req1 op2=0x40000000, sub=1 → add_op2=0xC0000000; response routed to rsp1 only.
- Contention: both valid every cycle, add_ready=1, stub latency 2 → grants alternate 0,1,0,1 starting with req0 after reset; responses return to 0,1,0,1 in order.
- Full: add_done held 0, continuous req0 → exactly 4 grants, then req0_ready=0. add_done in the full cycle → no grant that cycle, grant the next.
- Backpressure: add_ready=0 for 5 cycles → add_valid/add_op* stable, reqN_ready=0. add_ready=1 → issue accepted, and a new grant in the same cycle.
- Orphan and reset: add_done with empty queue → err_orphan=1 next cycle and sticky. Assert RST with 2 ops outstanding → all outputs return to reset values asynchronously, including err_orphan=0.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types for the two-requester FP add arbiter.
//   fpu_add_req_t : one add/sub request {op1, op2, sub, frm}
//   fpu_add_rsp_t : one adder response {result, flags}
//   req_id_t      : requester index carried through the order queue
package fpu_arb_pkg;

  localparam int unsigned FFLAGS_W = 5;

  typedef logic req_id_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sub;
    logic [2:0]  frm;
  } fpu_add_req_t;

  typedef struct packed {
    logic [31:0]         result;
    logic [FFLAGS_W-1:0] flags;
  } fpu_add_rsp_t;

  // a - b is issued as a + (-b): only the sign bit of op2 changes.
  function automatic logic [31:0] fold_sub(input logic [31:0] op2, input logic sub);
    return {op2[31] ^ sub, op2[30:0]};
  endfunction

endpackage

// File: rtl/fpu_tag_fifo.sv
// Order queue of requester IDs for operations in flight.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : enqueue din (ignored when full)
//   pop, dout    : dequeue; dout shows the oldest entry (ignored when empty)
//   empty, full  : occupancy flags derived from the internal count
module fpu_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one FP add datapath between two requesters.
// Round-robin grant into a registered issue stage; requester IDs are queued
// in issue order so each in-order add_done is routed back to its origin.
// Ports:
//   CLK, RST                      : clock, asynchronous active-high reset
//   reqN_valid/ready              : request handshake (N = 0, 1)
//   reqN_op1/op2/sub/frm          : operands, subtract flag, rounding mode
//   add_valid/ready, add_op*/frm  : issue register toward the adder
//   add_done/result/flags         : adder completion, in issue order
//   rspN_valid/result/flags       : one-cycle response pulse per requester
//   err_orphan                    : sticky, add_done seen with nothing in flight
module fpu_add_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [31:0]         req0_op1,
  input  logic [31:0]         req0_op2,
  input  logic                req0_sub,
  input  logic [2:0]          req0_frm,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [31:0]         req1_op1,
  input  logic [31:0]         req1_op2,
  input  logic                req1_sub,
  input  logic [2:0]          req1_frm,
  output logic                add_valid,
  input  logic                add_ready,
  output logic [31:0]         add_op1,
  output logic [31:0]         add_op2,
  output logic [2:0]          add_frm,
  input  logic                add_done,
  input  logic [31:0]         add_result,
  input  logic [FFLAGS_W-1:0] add_flags,
  output logic                rsp0_valid,
  output logic [31:0]         rsp0_result,
  output logic [FFLAGS_W-1:0] rsp0_flags,
  output logic                rsp1_valid,
  output logic [31:0]         rsp1_result,
  output logic [FFLAGS_W-1:0] rsp1_flags,
  output logic                err_orphan
);

  fpu_add_req_t w_req0;
  fpu_add_req_t w_req1;
  fpu_add_req_t w_sel;
  logic         w_issue_free;
  logic         w_can_grant;
  logic         w_pick1;
  logic         w_grant;
  logic         w_empty;
  logic         w_full;
  logic         w_rsp_fire;
  req_id_t      w_pop_id;

  req_id_t      r_prio;
  logic         r_add_valid;
  logic [31:0]  r_add_op1;
  logic [31:0]  r_add_op2;
  logic [2:0]   r_add_frm;
  logic         r_rsp0_valid;
  logic         r_rsp1_valid;
  fpu_add_rsp_t r_rsp0;
  fpu_add_rsp_t r_rsp1;
  logic         r_err_orphan;

  assign w_req0 = {req0_op1, req0_op2, req0_sub, req0_frm};
  assign w_req1 = {req1_op1, req1_op2, req1_sub, req1_frm};

  // Fullness is the registered count at cycle start, so an add_done in the
  // same cycle cannot open a slot; ready stays independent of add_done.
  assign w_issue_free = ~r_add_valid | add_ready;
  assign w_can_grant  = ~w_full & w_issue_free;

  // Requester 1 wins when it is alone or when both ask and it holds priority.
  assign w_pick1    = req1_valid & (~req0_valid | r_prio);
  assign req0_ready = w_can_grant & req0_valid & ~w_pick1;
  assign req1_ready = w_can_grant & w_pick1;
  assign w_grant    = req0_ready | req1_ready;
  assign w_sel      = w_pick1 ? w_req1 : w_req0;

  assign w_rsp_fire = add_done & ~w_empty;

  fpu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_order_q (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_grant),
    .pop   (add_done),
    .din   (w_pick1),
    .dout  (w_pop_id),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prio      <= 1'b0;
      r_add_valid <= 1'b0;
      r_add_op1   <= '0;
      r_add_op2   <= '0;
      r_add_frm   <= '0;
    end else begin
      if (w_grant) begin
        r_prio      <= ~w_pick1;
        r_add_valid <= 1'b1;
        r_add_op1   <= w_sel.op1;
        r_add_op2   <= fold_sub(w_sel.op2, w_sel.sub);
        r_add_frm   <= w_sel.frm;
      end else if (add_ready) begin
        r_add_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0       <= '0;
      r_rsp1       <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_rsp0_valid <= w_rsp_fire & ~w_pop_id;
      r_rsp1_valid <= w_rsp_fire & w_pop_id;
      if (w_rsp_fire & ~w_pop_id) r_rsp0 <= {add_result, add_flags};
      if (w_rsp_fire & w_pop_id)  r_rsp1 <= {add_result, add_flags};
      if (add_done & w_empty)     r_err_orphan <= 1'b1;
    end
  end

  assign add_valid   = r_add_valid;
  assign add_op1     = r_add_op1;
  assign add_op2     = r_add_op2;
  assign add_frm     = r_add_frm;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0.result;
  assign rsp0_flags  = r_rsp0.flags;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1.result;
  assign rsp1_flags  = r_rsp1.flags;
  assign err_orphan  = r_err_orphan;

endmodule
